// File: rtl/alu_nibble_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer.
package alu_nibble_seq_pkg;

  // Request opcodes seen on req_op
  typedef enum logic [1:0] {
    OpAnd = 2'd0,
    OpOr  = 2'd1,
    OpAdd = 2'd2,
    OpSub = 2'd3
  } op_e;

  // Operation codes understood by the external 4-bit ALU (3 is its set-less-than, unused here)
  localparam logic [1:0] AluOpAnd   = 2'd0;
  localparam logic [1:0] AluOpOr    = 2'd1;
  localparam logic [1:0] AluOpArith = 2'd2;

  // Controller states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_arith(op_e op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// Runs WORD_W-bit AND/OR/ADD/SUB on an external 4-bit ALU, one nibble per cycle,
// LSB nibble first, chaining the carry through carry_r.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_res,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              rsp_zero,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic              alu_binv,
  output logic              alu_cin,
  output logic [1:0]        alu_op,
  input  logic [3:0]        alu_res,
  input  logic              alu_cout
);

  localparam int unsigned NIB = WORD_W / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e            state;
  logic [IDX_W-1:0]  idx;
  op_e               op_r;
  logic [WORD_W-1:0] a_r;
  logic [WORD_W-1:0] b_r;
  logic [WORD_W-1:0] res_r;
  logic              carry_r;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [WORD_W-1:0] res_next;
  logic              arith;
  logic              sub;
  logic              ovf_next;

  assign arith     = is_arith(op_r);
  assign sub       = (op_r == OpSub);
  assign req_ready = (state == StIdle);
  assign rsp_zero  = (rsp_res == '0);

  // Final-nibble overflow uses the effective (possibly inverted) B sign bit
  assign ovf_next = (a_r[WORD_W-1] == (b_r[WORD_W-1] ^ sub)) &&
                    (alu_res[3] != a_r[WORD_W-1]);

  // Select the current operand nibbles and merge the ALU result into the working word
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    res_next = res_r;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib               = a_r[4*i +: 4];
        b_nib               = b_r[4*i +: 4];
        res_next[4*i +: 4]  = alu_res;
      end
    end
  end

  // ALU drive: active only while running, zero otherwise
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_binv = 1'b0;
    alu_cin  = 1'b0;
    alu_op   = AluOpAnd;
    if (state == StRun) begin
      alu_a    = a_nib;
      alu_b    = b_nib;
      alu_binv = sub;
      alu_cin  = arith ? carry_r : 1'b0;
      alu_op   = arith ? AluOpArith : 2'(op_r);
    end
  end

  // Sequencer FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      idx       <= '0;
      op_r      <= OpAnd;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      carry_r   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            op_r    <= op_e'(req_op);
            a_r     <= req_a;
            b_r     <= req_b;
            idx     <= '0;
            // SUB is A + ~B + 1, so the first nibble starts with carry set
            carry_r <= (req_op == 2'(OpSub));
            state   <= StRun;
          end
        end
        StRun: begin
          res_r   <= res_next;
          carry_r <= arith ? alu_cout : 1'b0;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            rsp_res   <= res_next;
            rsp_cout  <= arith & alu_cout;
            rsp_ovf   <= arith & ovf_next;
            rsp_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: supplies a behavioural 4-bit ALU, drives a vector table
// plus backpressure and reset-abort sequences, and scoreboards the responses.
module tb_alu_nibble_seq;

  localparam int unsigned WORD_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [WORD_W-1:0] req_a;
  logic [WORD_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_res;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              rsp_zero;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic              alu_binv;
  logic              alu_cin;
  logic [1:0]        alu_op;
  logic [3:0]        alu_res;
  logic              alu_cout;

  always #5 clk = ~clk;

  alu_nibble_seq #(.WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_binv  (alu_binv),
    .alu_cin   (alu_cin),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout)
  );

  // Behavioural 4-bit ALU
  logic [3:0] alu_beff;
  logic [4:0] alu_sum;
  assign alu_beff = alu_b ^ {4{alu_binv}};
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_beff} + {4'b0, alu_cin};
  assign alu_cout = alu_sum[4];
  always_comb begin
    alu_res = 4'h0;
    case (alu_op)
      2'd0:    alu_res = alu_a & alu_beff;
      2'd1:    alu_res = alu_a | alu_beff;
      2'd2:    alu_res = alu_sum[3:0];
      default: alu_res = 4'h0;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, 32'(rsp_res), 32'(e.res));
      check({tag, "_cout"}, 32'(rsp_cout), 32'(e.cout));
      check({tag, "_ovf"}, 32'(rsp_ovf), 32'(e.ovf));
      check({tag, "_zero"}, 32'(rsp_zero), 32'(e.zero));
    end
  endtask

  // One full transaction: issue, watch the ALU drive per nibble, check response, hand shake
  task automatic run_op(input vec_t v, input string tag);
    exp_t       e;
    int         cyc;
    logic       exp_cin;
    logic       arith;
    logic [3:0] an;
    logic [3:0] bn;
    logic [4:0] s;
    arith   = (v.op >= 2'd2);
    exp_cin = (v.op == 2'd3);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    e.res = v.res; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      if (cyc < 2) begin
        an = v.a[4*cyc +: 4];
        bn = v.b[4*cyc +: 4];
        check({tag, "_alu_a"}, 32'(alu_a), 32'(an));
        check({tag, "_alu_b"}, 32'(alu_b), 32'(bn));
        check({tag, "_alu_binv"}, 32'(alu_binv), 32'(v.op == 2'd3));
        check({tag, "_alu_cin"}, 32'(alu_cin), 32'(arith ? exp_cin : 1'b0));
        check({tag, "_alu_op"}, 32'(alu_op), arith ? 32'd2 : 32'(v.op));
        check({tag, "_req_ready_run"}, 32'(req_ready), 32'd0);
        s = {1'b0, an} + {1'b0, bn ^ {4{v.op == 2'd3}}} + {4'b0, exp_cin};
        exp_cin = s[4];
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_rsp(tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc;
    vec_t v;
    logic [7:0] held;

    vecs[0] = '{2'd2, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{2'd3, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'd3, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_res", 32'(rsp_res), 32'd0);
    check("reset_rsp_zero", 32'(rsp_zero), 32'd1);
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_alu_cin", 32'(alu_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with stray requests during RUN and DONE
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; req_a = 8'h05; req_b = 8'h03;
    @(posedge clk);
    e.res = 8'h02; e.cout = 1'b1; e.ovf = 1'b0; e.zero = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    req_op = 2'd2; req_a = 8'hFF; req_b = 8'hFF;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'd2);
    held = rsp_res;
    for (int k = 0; k < 5; k++) begin
      req_valid = k[0];
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_res", 32'(rsp_res), 32'h02);
      check("bp_rsp_stable", 32'(rsp_res), 32'(held));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    check_rsp("bp");
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_idle_req_ready", 32'(req_ready), 32'd1);
    check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_phantom_op", 32'(req_ready), 32'd1);
      check("bp_no_phantom_rsp", 32'(rsp_valid), 32'd0);
    end

    // Asynchronous reset in the first RUN cycle aborts the operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_a = 8'h5A; req_b = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_in_run_alu_a", 32'(alu_a), 32'hA);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_async_rsp_res", 32'(rsp_res), 32'd0);
    check("rst_async_req_ready", 32'(req_ready), 32'd1);
    check("rst_async_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_response", 32'(rsp_valid), 32'd0);
    end
    v = '{2'd2, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0};
    run_op(v, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle controller that runs WORD_W-bit AND/OR/ADD/SUB operations on the existing 4-bit ALU.
- Processes one 4-bit nibble per cycle, LSB nibble first, and chains the carry through a register between nibbles.
- Sits between an issuing unit (valid/ready request, valid/ready response) and one combinational 4-bit ALU instance.
- Drives the ALU's operand, binv, cin and operation inputs.

Parameters:
- WORD_W, 8, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WORD_W/4, derived nibble count; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  0=AND, 1=OR, 2=ADD, 3=SUB.
- req_a  in  WORD_W  operand A.
- req_b  in  WORD_W  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_res  out  WORD_W  result.
- rsp_cout  out  1  carry out of MSB nibble; 0 for logic ops.
- rsp_ovf  out  1  signed overflow; 0 for logic ops.
- rsp_zero  out  1  rsp_res == 0.
- alu_a  out  4  nibble of A to the ALU.
- alu_b  out  4  nibble of B to the ALU.
- alu_binv  out  1  invert B (1 only for SUB).
- alu_cin  out  1  ALU carry-in.
- alu_op  out  2  ALU operation: 0=AND, 1=OR, 2=add/sub.
- alu_res  in  4  ALU result, combinational from the alu_* outputs in the same cycle.
- alu_cout  in  1  ALU carry out.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE; idx=0; carry_r=0; all captured registers 0; rsp_valid=0; rsp_res=0; rsp_cout=0; rsp_ovf=0.
  - rsp_zero follows rsp_res, so it reads 1 after reset.
  - alu_* outputs are 0 in IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: capture op/a/b; idx<=0; carry_r<=(op==SUB); go to RUN.
- RUN:
  - req_ready=0; req_valid is ignored.
  - Combinational drive: alu_a=a_r[4*idx+:4]; alu_b=b_r[4*idx+:4]; alu_binv=(op==SUB).
  - alu_cin=carry_r for ADD/SUB, 0 for logic ops.
  - alu_op=op for AND/OR, 2 for ADD/SUB.
  - Each edge: res_r[4*idx+:4]<=alu_res; carry_r<=alu_cout for arithmetic, else 0; idx<=idx+1.
  - At idx==NIB-1 the edge also registers rsp_cout and rsp_ovf, then moves to DONE.
  - rsp_ovf = (a_msb == b_eff_msb) && (res_msb != a_msb), where b_eff = b XOR binv.
  - rsp_res, rsp_cout and rsp_ovf change only on this final RUN edge, never mid-operation.
- DONE:
  - rsp_valid=1; outputs held stable while rsp_ready=0.
  - On rsp_ready at an edge: go to IDLE and drop rsp_valid.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: accept edge, then NIB RUN cycles; rsp_valid rises on the NIB-th edge after accept (8 bits -> 2 cycles).
- Throughput: one operation per NIB+2 cycles at best.
- Carry semantics: SUB is A + ~B + 1; rsp_cout=1 means no borrow. All arithmetic wraps modulo 2^WORD_W.
- NIB==1 (WORD_W=4) is legal: RUN lasts one cycle.
- Reset asserted in RUN or DONE aborts the operation. No response is produced, and req_ready=1 the first cycle after reset deasserts.
- The idx counter is clog2(NIB) bits wide, minimum 1 bit.

Decomposition:
- Shared header alu_defs.vh holds:
  - request opcode encodings OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3;
  - ALU operation encodings ALUOP_AND=0, ALUOP_OR=1, ALUOP_ARITH=2, ALUOP_LESS=3;
  - state encodings S_IDLE, S_RUN, S_DONE.
- No sub-module inside the controller.
- The bench instantiates alu_nibble_seq plus the 4-bit ALU as a top-level pair named alu_seq_top.

Test Plan:
- ADD 0x5A+0x3C (WORD_W=8) -> rsp_res=0x96, cout=0, ovf=1, zero=0; rsp_valid 2 cycles after accept; alu_cin=0 then 1 across the two nibbles.
- ADD 0xFF+0x01 -> res=0x00, cout=1, ovf=0, zero=1. SUB 0x05-0x03 -> res=0x02, cout=1, ovf=0.
- SUB 0x00-0x01 -> res=0xFF, cout=0, ovf=0. SUB 0x80-0x01 -> res=0x7F, ovf=1.
- AND 0xF0&0x3C -> 0x30 and OR 0xF0|0x0C -> 0xFC; both with cout=0, ovf=0, alu_binv=0, alu_cin=0 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0. Pulse a second req_valid during RUN/DONE -> it is ignored (no capture). Release rsp_ready -> IDLE next cycle.
- Assert rst in the first RUN cycle of ADD 0x5A+0x3C -> rsp_valid=0, rsp_res=0, state IDLE immediately (async). After deassert, ADD 0x11+0x22 completes normally -> 0x33.
